// File: rtl/ibex_rst_seq_if.sv
// ibex_rst_seq_if: signal bundle between the reset sequencer and the system around it.
//   master: sequencer side; takes pll_locked, sw_rst_req and the watchdog
//           controls, drives rst_out_n, sys_ready and rst_cause.
//   slave : system side; the mirror image of master.
interface ibex_rst_seq_if #(
   parameter int N_RST     = 3,
   parameter int WDT_WIDTH = 24
);
   logic                 pll_locked;
   logic                 sw_rst_req;
   logic                 wdt_en;
   logic                 wdt_kick;
   logic [WDT_WIDTH-1:0] wdt_load;
   logic [N_RST-1:0]     rst_out_n;
   logic                 sys_ready;
   logic [3:0]           rst_cause;
   modport master (
      input  pll_locked, sw_rst_req, wdt_en, wdt_kick, wdt_load,
      output rst_out_n, sys_ready, rst_cause
   );
   modport slave (
      output pll_locked, sw_rst_req, wdt_en, wdt_kick, wdt_load,
      input  rst_out_n, sys_ready, rst_cause
   );
endinterface

// File: rtl/ibex_rst_seq.sv
// ibex_rst_seq: waits for a stable PLL lock, then releases the reset domains one by one.
//   clk_sys : only clock
//   rst_sys : synchronous active-high reset
//   bus     : ibex_rst_seq_if.master (PLL lock, software reset, watchdog in;
//             per-domain active-low resets, sys_ready, one-hot reset cause out)
module ibex_rst_seq #(
   parameter int N_RST         = 3,
   parameter int LOCK_CYCLES   = 1024,
   parameter int STAGGER       = 16,
   parameter int SW_RST_CYCLES = 8,
   parameter int WDT_WIDTH     = 24
) (
   input  logic         clk_sys,
   input  logic         rst_sys,
   ibex_rst_seq_if.master bus
);
   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam int SW = $clog2(STAGGER + 1);
   localparam int HW = $clog2(SW_RST_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
   localparam logic [SW-1:0] STG_LAST  = SW'(STAGGER - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(SW_RST_CYCLES - 1);

   typedef enum logic [2:0] {HOLD, LOCK_WAIT, RELEASE, RUN, SW_HOLD} state_e;

   state_e               state_q, state_d;
   logic [LW-1:0]        lock_q, lock_d;
   logic [SW-1:0]        stg_q, stg_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [WDT_WIDTH-1:0] wdt_q, wdt_d;
   logic [N_RST-1:0]     rst_n_q, rst_n_d;
   logic                 ready_q, ready_d;
   logic [3:0]           cause_q, cause_d;

   logic             pll_loss, wdt_exp, sw_hit, enter_rel, step, keep;
   logic [N_RST-1:0] rst_shift;

   assign pll_loss  = !bus.pll_locked && (state_q == RELEASE || state_q == RUN || state_q == SW_HOLD);
   assign wdt_exp   = state_q == RUN && wdt_q == '0 && bus.wdt_en && !bus.wdt_kick;
   assign sw_hit    = state_q == RUN && bus.sw_rst_req;
   // Domain 0 comes out of reset either after the lock count or after a software/watchdog hold.
   assign enter_rel = bus.pll_locked && ((state_q == LOCK_WAIT && lock_q == LOCK_LAST) ||
                                         (state_q == SW_HOLD && hold_q == HOLD_LAST));
   assign step      = bus.pll_locked && state_q == RELEASE && stg_q == STG_LAST;
   assign keep      = (state_q == RELEASE || state_q == RUN) && !pll_loss && !wdt_exp && !sw_hit;
   // Releasing the next domain shifts a one in from the bottom, so order is preserved.
   assign rst_shift = N_RST'({rst_n_q, 1'b1});

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         state_q <= HOLD;
         lock_q  <= '0;
         stg_q   <= '0;
         hold_q  <= '0;
         wdt_q   <= bus.wdt_load;
         rst_n_q <= '0;
         ready_q <= 1'b0;
         cause_q <= 4'b0001;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         stg_q   <= stg_d;
         hold_q  <= hold_d;
         wdt_q   <= wdt_d;
         rst_n_q <= rst_n_d;
         ready_q <= ready_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = pll_loss                              ? LOCK_WAIT :
                (wdt_exp || sw_hit)                   ? SW_HOLD   :
                ((enter_rel || step) && &rst_n_d)     ? RUN       :
                enter_rel                             ? RELEASE   :
                (state_q == HOLD)                     ? LOCK_WAIT : state_q;
   end

   always_comb begin
      lock_d  = (state_q == LOCK_WAIT && bus.pll_locked) ? lock_q + 1'b1 : '0;
      stg_d   = (state_q == RELEASE && stg_q != STG_LAST) ? stg_q + 1'b1 : '0;
      hold_d  = (state_q == SW_HOLD && hold_q != HOLD_LAST) ? hold_q + 1'b1 : '0;
      // Reload outside RUN, on entry and on exit so every RUN visit starts from wdt_load.
      wdt_d   = (state_q != RUN || pll_loss || wdt_exp || sw_hit || !bus.wdt_en || bus.wdt_kick) ?
                bus.wdt_load : wdt_q - 1'b1;
      rst_n_d = enter_rel ? N_RST'(1) : step ? rst_shift : keep ? rst_n_q : '0;
      ready_d = &rst_n_d;
      cause_d = pll_loss ? 4'b0010 : wdt_exp ? 4'b1000 : sw_hit ? 4'b0100 : cause_q;
   end

   assign bus.rst_out_n = rst_n_q;
   assign bus.sys_ready = ready_q;
   assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_ibex_rst_seq.sv
// tb_ibex_rst_seq: directed scenarios for ibex_rst_seq with hand-computed edge timing.
module tb_ibex_rst_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   ibex_rst_seq_if #(.N_RST(3), .WDT_WIDTH(24)) bus ();

   ibex_rst_seq #(
      .N_RST(3), .LOCK_CYCLES(16), .STAGGER(4), .SW_RST_CYCLES(8), .WDT_WIDTH(24)
   ) dut (
      .clk_sys(clk),
      .rst_sys(rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.pll_locked = 1'b1;
      bus.sw_rst_req = 1'b0;
      bus.wdt_en = 1'b0;
      bus.wdt_kick = 1'b0;
      bus.wdt_load = 24'd10;
      repeat (3) tick();
      n_cmp++;
      if (bus.rst_out_n !== 3'b000) begin n_err++; $display("FAIL reset_rst got %b want 000", bus.rst_out_n); end
      n_cmp++;
      if (bus.sys_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", bus.sys_ready); end
      n_cmp++;
      if (bus.rst_cause !== 4'b0001) begin n_err++; $display("FAIL reset_cause got %b want 0001", bus.rst_cause); end
   endtask

   task automatic test_cold_start;
      logic [2:0] exp;
      rst = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         tick();
         exp = {e >= 25, e >= 21, e >= 17};
         n_cmp++;
         if (bus.rst_out_n !== exp) begin n_err++; $display("FAIL cold_rst edge %0d got %b want %b", e, bus.rst_out_n, exp); end
         n_cmp++;
         if (bus.sys_ready !== (e >= 25)) begin n_err++; $display("FAIL cold_ready edge %0d got %b want %b", e, bus.sys_ready, e >= 25); end
         n_cmp++;
         if (bus.rst_cause !== 4'b0001) begin n_err++; $display("FAIL cold_cause edge %0d got %b want 0001", e, bus.rst_cause); end
      end
   endtask

   task automatic test_sw_reset;
      logic [2:0] exp;
      bus.sw_rst_req = 1'b1;
      tick();
      bus.sw_rst_req = 1'b0;
      n_cmp++;
      if (bus.rst_out_n !== 3'b000 || bus.sys_ready !== 1'b0) begin
         n_err++; $display("FAIL sw_assert got %b/%b want 000/0", bus.rst_out_n, bus.sys_ready);
      end
      n_cmp++;
      if (bus.rst_cause !== 4'b0100) begin n_err++; $display("FAIL sw_cause got %b want 0100", bus.rst_cause); end
      for (int k = 1; k <= 20; k++) begin
         bus.sw_rst_req = (k == 10);
         tick();
         bus.sw_rst_req = 1'b0;
         exp = {k >= 16, k >= 12, k >= 8};
         n_cmp++;
         if (bus.rst_out_n !== exp) begin n_err++; $display("FAIL sw_rel s+%0d got %b want %b", k, bus.rst_out_n, exp); end
         n_cmp++;
         if (bus.sys_ready !== (k >= 16)) begin n_err++; $display("FAIL sw_ready s+%0d got %b want %b", k, bus.sys_ready, k >= 16); end
      end
      n_cmp++;
      if (bus.rst_cause !== 4'b0100) begin n_err++; $display("FAIL sw_cause_hold got %b want 0100", bus.rst_cause); end
   endtask

   task automatic test_watchdog;
      bus.wdt_en = 1'b1;
      for (int i = 0; i < 33; i++) begin
         bus.wdt_kick = (i % 8 == 0);
         tick();
         bus.wdt_kick = 1'b0;
         n_cmp++;
         if (bus.rst_out_n !== 3'b111) begin n_err++; $display("FAIL wdt_kicked cyc %0d got %b want 111", i, bus.rst_out_n); end
      end
      for (int k = 1; k <= 11; k++) begin
         tick();
         n_cmp++;
         if (bus.rst_out_n !== (k == 11 ? 3'b000 : 3'b111)) begin
            n_err++; $display("FAIL wdt_expire K+%0d got %b want %b", k, bus.rst_out_n, k == 11 ? 3'b000 : 3'b111);
         end
      end
      n_cmp++;
      if (bus.rst_cause !== 4'b1000) begin n_err++; $display("FAIL wdt_cause got %b want 1000", bus.rst_cause); end
      bus.wdt_en = 1'b0;
      repeat (16) tick();
      n_cmp++;
      if (bus.sys_ready !== 1'b1) begin n_err++; $display("FAIL wdt_rerelease got %b want 1", bus.sys_ready); end
      bus.wdt_en = 1'b1;
      bus.wdt_kick = 1'b1;
      tick();
      bus.wdt_kick = 1'b0;
      repeat (10) tick();
      bus.wdt_kick = 1'b1;
      tick();
      bus.wdt_kick = 1'b0;
      n_cmp++;
      if (bus.rst_out_n !== 3'b111 || bus.sys_ready !== 1'b1) begin
         n_err++; $display("FAIL wdt_kick_on_expiry got %b/%b want 111/1", bus.rst_out_n, bus.sys_ready);
      end
      tick();
      n_cmp++;
      if (bus.rst_out_n !== 3'b111) begin n_err++; $display("FAIL wdt_after_kick got %b want 111", bus.rst_out_n); end
      bus.wdt_en = 1'b0;
      tick();
   endtask

   task automatic test_pll_loss;
      logic [2:0] exp;
      bus.pll_locked = 1'b0;
      bus.sw_rst_req = 1'b1;
      tick();
      bus.pll_locked = 1'b1;
      bus.sw_rst_req = 1'b0;
      n_cmp++;
      if (bus.rst_out_n !== 3'b000 || bus.sys_ready !== 1'b0) begin
         n_err++; $display("FAIL pll_assert got %b/%b want 000/0", bus.rst_out_n, bus.sys_ready);
      end
      n_cmp++;
      if (bus.rst_cause !== 4'b0010) begin n_err++; $display("FAIL pll_cause got %b want 0010", bus.rst_cause); end
      for (int k = 1; k <= 26; k++) begin
         tick();
         exp = {k >= 24, k >= 20, k >= 16};
         n_cmp++;
         if (bus.rst_out_n !== exp) begin n_err++; $display("FAIL pll_rel g+%0d got %b want %b", k, bus.rst_out_n, exp); end
      end
      n_cmp++;
      if (bus.sys_ready !== 1'b1) begin n_err++; $display("FAIL pll_ready got %b want 1", bus.sys_ready); end
   endtask

   task automatic test_rst_mid_release;
      bus.pll_locked = 1'b0;
      tick();
      bus.pll_locked = 1'b1;
      repeat (20) tick();
      n_cmp++;
      if (bus.rst_out_n !== 3'b011) begin n_err++; $display("FAIL mid_pre got %b want 011", bus.rst_out_n); end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (bus.rst_out_n !== 3'b000 || bus.sys_ready !== 1'b0) begin
         n_err++; $display("FAIL mid_assert got %b/%b want 000/0", bus.rst_out_n, bus.sys_ready);
      end
      n_cmp++;
      if (bus.rst_cause !== 4'b0001) begin n_err++; $display("FAIL mid_cause got %b want 0001", bus.rst_cause); end
      test_cold_start();
   endtask

   task automatic test_lock_glitch;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 28; e++) begin
         bus.pll_locked = (e != 12);
         tick();
         n_cmp++;
         if (bus.rst_out_n[0] !== (e >= 28)) begin
            n_err++; $display("FAIL glitch_rst0 edge %0d got %b want %b", e, bus.rst_out_n[0], e >= 28);
         end
      end
      bus.pll_locked = 1'b1;
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_sw_reset();
      test_watchdog();
      test_pll_loss();
      test_rst_mid_release();
      test_lock_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ibex_rst_seq.md
# ibex_rst_seq

Parametrised clock-ready/reset sequencer for the ibex system tops. It waits for the PLL lock to be stable, then releases N_RST active-low reset domains one at a time, spaced STAGGER cycles apart (e.g. core, bus, peripherals). It also provides a software-reset path and a watchdog, and latches the cause of the last reset. It sits between the PLL and the system instance, clocked by the PLL output.

## Interface
Parameters:
- N_RST, 3: number of reset domains; index 0 is released first (N_RST ≥ 1).
- LOCK_CYCLES, 1024: consecutive pll_locked cycles required before release (≥ 1).
- STAGGER, 16: cycles between successive domain releases (≥ 1).
- SW_RST_CYCLES, 8: hold time of a software/watchdog reset (≥ 1).
- WDT_WIDTH, 24: watchdog counter width.

Ports:
- clk_sys  in  1  system clock; this is the only clock.
- rst_sys  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock status, already synchronous to clk_sys.
- sw_rst_req  in  1  software reset request; level or pulse, sampled only in RUN.
- wdt_en  in  1  watchdog enable.
- wdt_kick  in  1  watchdog reload strobe.
- wdt_load  in  WDT_WIDTH  watchdog reload value.
- rst_out_n  out  N_RST  per-domain active-low resets.
- sys_ready  out  1  high when all domains are released.
- rst_cause  out  4  one-hot cause of the last reset: bit0 external, bit1 PLL loss, bit2 software, bit3 watchdog.

## Operation
- All outputs are registered.
- While rst_sys=1:
  - state HOLD, rst_out_n=0, sys_ready=0, rst_cause=4'b0001.
  - Lock, stagger and hold counters are 0; the watchdog counter equals wdt_load.
- HOLD moves to LOCK_WAIT on the first edge with rst_sys=0.
- LOCK_WAIT:
  - The lock counter (width $clog2(LOCK_CYCLES+1)) increments while pll_locked=1 and clears when pll_locked=0.
  - When the count reaches LOCK_CYCLES, the block enters RELEASE and sets rst_out_n[0]=1 on that same edge.
- RELEASE:
  - The stagger counter sets rst_out_n[k]=1 exactly k*STAGGER edges after rst_out_n[0].
  - Released bits stay high; bits are never released out of order.
  - On the edge that releases rst_out_n[N_RST-1], the state becomes RUN and sys_ready=1.
  - With N_RST=1, RUN and sys_ready are entered on the same edge as rst_out_n[0].
- RUN:
  - Watchdog counter is loaded with wdt_load on RUN entry.
  - With wdt_en=1, the counter decrements by 1 per edge.
  - wdt_kick=1 reloads it with wdt_load; kick takes priority over decrement and over expiry in the same cycle.
  - With wdt_en=0, the counter holds wdt_load.
  - Expiry: counter==0 and wdt_en=1 and wdt_kick=0 → SW_HOLD, rst_cause=4'b1000.
  - sw_rst_req=1 → SW_HOLD, rst_cause=4'b0100.
- SW_HOLD:
  - On the entry edge, rst_out_n=0 and sys_ready=0.
  - The block holds for SW_RST_CYCLES edges, then enters RELEASE. rst_out_n[0] rises at entry+SW_RST_CYCLES.
  - There is no lock wait, because the PLL is already locked.
- PLL loss: pll_locked=0 sampled in RELEASE, RUN or SW_HOLD causes the following on that edge:
  - rst_out_n=0, sys_ready=0, rst_cause=4'b0010.
  - State LOCK_WAIT with the lock counter at 0.
- Event priority, highest first: rst_sys > PLL loss > watchdog expiry > sw_rst_req.
  - sw_rst_req outside RUN is ignored.
  - The watchdog is inactive outside RUN and is reloaded on leaving RUN.
- rst_cause changes only on reset entry and holds until the next reset event.
- rst_sys asserted mid-sequence in any state overrides everything on that edge.

## Timing
- Cold start with pll_locked high throughout:
  - rst_out_n[0] rises on the (LOCK_CYCLES+1)th edge sampling rst_sys=0.
  - rst_out_n[k] rises k*STAGGER edges later.
  - sys_ready rises with rst_out_n[N_RST-1].
- Software/PLL-loss/watchdog reset assertion latency is 0: outputs go low on the edge the event is sampled.
- With wdt_en=1 and no kicks from RUN entry, the watchdog reset asserts at entry+wdt_load+1. wdt_load=0 expires at entry+1.
- A pll_locked glitch of one cycle during LOCK_WAIT restarts the full LOCK_CYCLES count.

## Test plan
- Cold start: N_RST=3, LOCK_CYCLES=16, STAGGER=4, pll_locked=1 → rst_out_n bits rise at edges 17, 21 and 25; sys_ready rises at edge 25; rst_cause=0001.
- Lock glitch: pll_locked drops for 1 cycle at LOCK_WAIT count 10 → count restarts; rst_out_n[0] rises 16 edges after pll_locked returns.
- Software reset: SW_RST_CYCLES=8, sw_rst_req pulse in RUN at edge s → all outputs 0 at s, rst_cause=0100; rst_out_n[0] rises at s+8, [1] at s+12, [2] and sys_ready at s+16. A sw_rst_req during RELEASE is ignored.
- Watchdog: wdt_load=10, wdt_en=1.
  - Kicks every 8 cycles → no reset.
  - Kicks stop → reset 11 edges after the last kick edge, rst_cause=1000.
  - Kick on the expiry cycle → no reset.
- PLL loss in RUN → all rst_out_n=0 on the same edge, rst_cause=0010, full LOCK_WAIT re-run. Simultaneous sw_rst_req → cause stays 0010.
- rst_sys asserted mid-RELEASE → all outputs 0 and rst_cause=0001 on the next edge; restart timing is identical to the cold start.
